ssb_host_arbiter: RTL and testbench

//  Shares the single-ported system bus (SRAM + debug memory) between bus hosts:

---
 rtl/ssb_host_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ssb_host_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssb_host_arbiter.sv
// ssb_host_arbiter
//   Shares the single-ported system bus (SRAM + debug memory) between bus
//   hosts: host 0 = debug module SBA, host 1 = Ibex instr, host 2 = Ibex data.
//   One transaction is outstanding at a time. Host 0 can optionally win
//   outright; the remaining hosts share the bus round-robin. A response
//   watchdog answers with an error when the device never responds.
//
// Handshake (both sides): a request is presented with req=1 and its fields
//   stable; it is accepted in the cycle where gnt=1. Exactly one rvalid
//   follows each accepted request. rdata/err are only meaningful while rvalid=1.
//
// Ports
//   clk_sys_i, rst_sys_i          clock, asynchronous active-high reset
//   host_req_i/we_i               per-host request / write enable
//   host_be_i/addr_i/wdata_i      per-host fields, packed, host h in slice h
//   host_gnt_o, host_rvalid_o     one-hot or zero grant / response valid
//   host_err_o, host_rdata_o      shared response error / read data
//   dev_req_o/we_o/be_o/addr_o/wdata_o  selected host request (zero when idle)
//   dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i  device side
//   busy_o                        high in HOLD or RESP
//   owner_o                       owning host index, 0 when idle
module ssb_host_arbiter #(
  parameter int NumHosts      = 3,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int PrioHost0     = 1,
  parameter int TimeoutCycles = 255
) (
  input  logic                              clk_sys_i,
  input  logic                              rst_sys_i,
  input  logic [NumHosts-1:0]               host_req_i,
  input  logic [NumHosts-1:0]               host_we_i,
  input  logic [NumHosts*(DataWidth/8)-1:0] host_be_i,
  input  logic [NumHosts*AddrWidth-1:0]     host_addr_i,
  input  logic [NumHosts*DataWidth-1:0]     host_wdata_i,
  output logic [NumHosts-1:0]               host_gnt_o,
  output logic [NumHosts-1:0]               host_rvalid_o,
  output logic                              host_err_o,
  output logic [DataWidth-1:0]              host_rdata_o,
  output logic                              dev_req_o,
  output logic                              dev_we_o,
  output logic [DataWidth/8-1:0]            dev_be_o,
  output logic [AddrWidth-1:0]              dev_addr_o,
  output logic [DataWidth-1:0]              dev_wdata_o,
  input  logic                              dev_gnt_i,
  input  logic                              dev_rvalid_i,
  input  logic [DataWidth-1:0]              dev_rdata_i,
  input  logic                              dev_err_i,
  output logic                              busy_o,
  output logic [$clog2(NumHosts)-1:0]       owner_o
);

  localparam int BeW  = DataWidth / 8;
  localparam int IdxW = $clog2(NumHosts);
  // Keep the counter at least one bit wide so a disabled watchdog still elaborates.
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [IdxW-1:0] owner_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic [CntW-1:0] cnt_q;

  logic            win_valid;
  logic [IdxW-1:0] win_idx;
  logic [IdxW:0]   cand_sum;
  logic [IdxW-1:0] cand;
  logic            drive;
  logic [IdxW-1:0] sel;
  logic            timeout;

  // Winner: host 0 outright when it has priority, otherwise the first
  // requester after the RR pointer. With priority on, host 0 is excluded from
  // the cyclic search so it never disturbs the RR order of the others.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    if ((PrioHost0 != 0) && host_req_i[0]) begin
      win_valid = 1'b1;
    end else begin
      for (int i = 1; i <= NumHosts; i++) begin
        cand_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
        if (cand_sum >= (IdxW+1)'(NumHosts)) cand_sum = cand_sum - (IdxW+1)'(NumHosts);
        cand = cand_sum[IdxW-1:0];
        if (!win_valid && host_req_i[cand] && !((PrioHost0 != 0) && (cand == '0))) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  // In HOLD the owner is locked; no re-arbitration until it is granted or withdraws.
  assign sel     = (state_q == S_HOLD) ? owner_q : win_idx;
  assign drive   = ((state_q == S_IDLE) && win_valid) ||
                   ((state_q == S_HOLD) && host_req_i[owner_q]);
  assign timeout = (TimeoutCycles != 0) && (cnt_q == CntLast) && !dev_rvalid_i;

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= IdxW'(NumHosts - 1);
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            owner_q <= win_idx;
            if (dev_gnt_i) begin
              state_q <= S_RESP;
              cnt_q   <= '0;
              if (!((PrioHost0 != 0) && (win_idx == '0))) rr_ptr_q <= win_idx;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!host_req_i[owner_q]) begin
            state_q <= S_IDLE;
          end else if (dev_gnt_i) begin
            state_q <= S_RESP;
            cnt_q   <= '0;
            if (!((PrioHost0 != 0) && (owner_q == '0))) rr_ptr_q <= owner_q;
          end
        end
        S_RESP: begin
          if (dev_rvalid_i || timeout) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // All outputs are combinational from state and inputs; reset gates them to
  // zero so an asserted reset silences the bus in the same cycle.
  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = 1'b0;
    host_rdata_o  = '0;
    dev_req_o     = 1'b0;
    dev_we_o      = 1'b0;
    dev_be_o      = '0;
    dev_addr_o    = '0;
    dev_wdata_o   = '0;
    busy_o        = 1'b0;
    owner_o       = '0;
    if (!rst_sys_i) begin
      busy_o  = (state_q != S_IDLE);
      owner_o = (state_q != S_IDLE) ? owner_q : '0;
      case (state_q)
        S_IDLE, S_HOLD: begin
          if (drive) begin
            dev_req_o       = 1'b1;
            dev_we_o        = host_we_i[sel];
            dev_be_o        = host_be_i[sel*BeW +: BeW];
            dev_addr_o      = host_addr_i[sel*AddrWidth +: AddrWidth];
            dev_wdata_o     = host_wdata_i[sel*DataWidth +: DataWidth];
            host_gnt_o[sel] = dev_gnt_i;
          end
        end
        S_RESP: begin
          if (dev_rvalid_i) begin
            host_rvalid_o[owner_q] = 1'b1;
            host_rdata_o           = dev_rdata_i;
            host_err_o             = dev_err_i;
          end else if (timeout) begin
            host_rvalid_o[owner_q] = 1'b1;
            host_err_o             = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ssb_host_arbiter.sv
// Bench for ssb_host_arbiter. Two instances share all inputs:
//   dut    : PrioHost0=1, TimeoutCycles=4
//   dut_rr : PrioHost0=0, TimeoutCycles=4 (used for the plain round-robin order)
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_ssb_host_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  host_req, host_we;
  logic [11:0] host_be;
  logic [95:0] host_addr, host_wdata;
  logic        dev_gnt, dev_rvalid, dev_err;
  logic [31:0] dev_rdata;

  logic [2:0]  host_gnt, host_rvalid;
  logic        host_err, dev_req, dev_we, busy;
  logic [31:0] host_rdata, dev_addr, dev_wdata;
  logic [3:0]  dev_be;
  logic [1:0]  owner;

  logic [2:0]  rr_gnt, rr_rvalid;
  logic        rr_err, rr_dev_req, rr_dev_we, rr_busy;
  logic [31:0] rr_rdata, rr_dev_addr, rr_dev_wdata;
  logic [3:0]  rr_dev_be;
  logic [1:0]  rr_owner;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ssb_host_arbiter #(.NumHosts(3), .AddrWidth(32), .DataWidth(32),
                     .PrioHost0(1), .TimeoutCycles(4)) dut (
    .clk_sys_i(clk), .rst_sys_i(rst),
    .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_err_o(host_err),
    .host_rdata_o(host_rdata), .dev_req_o(dev_req), .dev_we_o(dev_we),
    .dev_be_o(dev_be), .dev_addr_o(dev_addr), .dev_wdata_o(dev_wdata),
    .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
    .dev_err_i(dev_err), .busy_o(busy), .owner_o(owner)
  );

  ssb_host_arbiter #(.NumHosts(3), .AddrWidth(32), .DataWidth(32),
                     .PrioHost0(0), .TimeoutCycles(4)) dut_rr (
    .clk_sys_i(clk), .rst_sys_i(rst),
    .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(rr_gnt), .host_rvalid_o(rr_rvalid), .host_err_o(rr_err),
    .host_rdata_o(rr_rdata), .dev_req_o(rr_dev_req), .dev_we_o(rr_dev_we),
    .dev_be_o(rr_dev_be), .dev_addr_o(rr_dev_addr), .dev_wdata_o(rr_dev_wdata),
    .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata),
    .dev_err_i(dev_err), .busy_o(rr_busy), .owner_o(rr_owner)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    host_req   = '0;
    host_we    = '0;
    host_be    = '0;
    host_addr  = '0;
    host_wdata = '0;
    dev_gnt    = 1'b0;
    dev_rvalid = 1'b0;
    dev_err    = 1'b0;
    dev_rdata  = '0;
  endtask

  task automatic set_host(input int h, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd);
    host_we[h]             = we;
    host_be[h*4 +: 4]      = be;
    host_addr[h*32 +: 32]  = addr;
    host_wdata[h*32 +: 32] = wd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    clear_inputs();
    host_req   = 3'b111;
    dev_gnt    = 1'b1;
    dev_rvalid = 1'b1;
    dev_rdata  = 32'h1234_5678;
    set_host(1, 1'b1, 4'hF, 32'h80, 32'h55);
    #1;
    n_cmp++; if (dev_req !== 1'b0) begin n_err++; $display("FAIL reset_dev_req: got %b want 0", dev_req); end
    n_cmp++; if (host_gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt: got %b want 000", host_gnt); end
    n_cmp++; if (host_rvalid !== 3'b000) begin n_err++; $display("FAIL reset_rvalid: got %b want 000", host_rvalid); end
    n_cmp++; if (host_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", host_rdata); end
    n_cmp++; if (dev_addr !== 32'h0 || dev_we !== 1'b0) begin n_err++; $display("FAIL reset_dev_fields: got addr %h we %b want 0", dev_addr, dev_we); end
    n_cmp++; if (busy !== 1'b0 || owner !== 2'd0) begin n_err++; $display("FAIL reset_busy_owner: got %b/%0d want 0/0", busy, owner); end
    next_cycle();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || dev_req !== 1'b0) begin n_err++; $display("FAIL reset_idle_after: got busy %b req %b want 0/0", busy, dev_req); end
  endtask

  task automatic test_single_read();
    do_reset();
    set_host(1, 1'b0, 4'hF, 32'h0000_0080, 32'h0);
    host_req = 3'b010;
    dev_gnt  = 1'b1;
    @(negedge clk);
    n_cmp++; if (host_gnt !== 3'b010) begin n_err++; $display("FAIL single_gnt: got %b want 010", host_gnt); end
    n_cmp++; if (dev_req !== 1'b1 || dev_addr !== 32'h80) begin n_err++; $display("FAIL single_dev: got req %b addr %h want 1/00000080", dev_req, dev_addr); end
    n_cmp++; if (dev_be !== 4'hF || dev_we !== 1'b0) begin n_err++; $display("FAIL single_be_we: got %h/%b want f/0", dev_be, dev_we); end
    next_cycle();
    host_req   = 3'b000;
    dev_gnt    = 1'b0;
    dev_rvalid = 1'b1;
    dev_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (host_rvalid !== 3'b010) begin n_err++; $display("FAIL single_rvalid: got %b want 010", host_rvalid); end
    n_cmp++; if (host_rdata !== 32'hDEAD_BEEF || host_err !== 1'b0) begin n_err++; $display("FAIL single_rdata: got %h err %b want deadbeef/0", host_rdata, host_err); end
    n_cmp++; if (busy !== 1'b1 || owner !== 2'd1 || dev_req !== 1'b0) begin n_err++; $display("FAIL single_resp_state: got busy %b owner %0d req %b want 1/1/0", busy, owner, dev_req); end
    next_cycle();
    dev_rvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || host_rvalid !== 3'b000 || host_rdata !== 32'h0) begin n_err++; $display("FAIL single_idle: got busy %b rvalid %b rdata %h want 0/000/0", busy, host_rvalid, host_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  exp_gnt;
    logic [31:0] exp_addr;
    do_reset();
    set_host(1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
    set_host(2, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
    host_req = 3'b110;
    for (int k = 0; k < 4; k++) begin
      exp_gnt  = (k % 2 == 0) ? 3'b010 : 3'b100;
      exp_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
      dev_gnt    = 1'b1;
      dev_rvalid = 1'b0;
      @(negedge clk);
      n_cmp++; if (host_gnt !== exp_gnt || dev_addr !== exp_addr) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b addr %h want %b addr %h", k, host_gnt, dev_addr, exp_gnt, exp_addr); end
      next_cycle();
      dev_gnt    = 1'b0;
      dev_rvalid = 1'b1;
      dev_err    = (k == 1);
      dev_rdata  = 32'hA000_0000 + k;
      @(negedge clk);
      n_cmp++; if (host_rvalid !== exp_gnt || host_err !== (k == 1) || host_rdata !== 32'hA000_0000 + k) begin n_err++; $display("FAIL b2b_rsp[%0d]: got %b err %b rdata %h want %b err %b", k, host_rvalid, host_err, host_rdata, exp_gnt, (k == 1)); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    logic [2:0] exp_rr;
    do_reset();
    host_req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      exp_rr = (k % 3 == 0) ? 3'b001 : (k % 3 == 1) ? 3'b010 : 3'b100;
      dev_gnt    = 1'b1;
      dev_rvalid = 1'b0;
      @(negedge clk);
      n_cmp++; if (host_gnt !== 3'b001) begin n_err++; $display("FAIL prio_gnt[%0d]: got %b want 001", k, host_gnt); end
      n_cmp++; if (rr_gnt !== exp_rr) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, rr_gnt, exp_rr); end
      next_cycle();
      dev_gnt    = 1'b0;
      dev_rvalid = 1'b1;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_hold_lock();
    do_reset();
    set_host(1, 1'b0, 4'hF, 32'h0000_0111, 32'h0);
    set_host(0, 1'b1, 4'h3, 32'h0000_0040, 32'hCAFE_F00D);
    host_req = 3'b010;
    dev_gnt  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (dev_req !== 1'b1 || dev_addr !== 32'h111 || host_gnt !== 3'b000) begin n_err++; $display("FAIL hold_wait[%0d]: got req %b addr %h gnt %b want 1/00000111/000", c, dev_req, dev_addr, host_gnt); end
      next_cycle();
      host_req = 3'b011;
    end
    dev_gnt = 1'b1;
    @(negedge clk);
    n_cmp++; if (host_gnt !== 3'b010 || dev_addr !== 32'h111 || owner !== 2'd1) begin n_err++; $display("FAIL hold_gnt: got %b addr %h owner %0d want 010/00000111/1", host_gnt, dev_addr, owner); end
    next_cycle();
    dev_gnt    = 1'b0;
    dev_rvalid = 1'b1;
    @(negedge clk);
    n_cmp++; if (host_rvalid !== 3'b010) begin n_err++; $display("FAIL hold_rvalid: got %b want 010", host_rvalid); end
    next_cycle();
    dev_rvalid = 1'b0;
    dev_gnt    = 1'b1;
    @(negedge clk);
    n_cmp++; if (host_gnt !== 3'b001 || dev_addr !== 32'h40) begin n_err++; $display("FAIL hold_next_gnt: got %b addr %h want 001/00000040", host_gnt, dev_addr); end
    n_cmp++; if (dev_we !== 1'b1 || dev_be !== 4'h3 || dev_wdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL hold_next_fields: got we %b be %h wdata %h want 1/3/cafef00d", dev_we, dev_be, dev_wdata); end
    next_cycle();
    dev_gnt    = 1'b0;
    dev_rvalid = 1'b1;
    host_req   = 3'b000;
    next_cycle();
    // Owner withdraws while held: bus released without a grant.
    dev_rvalid = 1'b0;
    set_host(2, 1'b0, 4'hF, 32'h0000_0222, 32'h0);
    host_req   = 3'b100;
    next_cycle();
    host_req = 3'b000;
    @(negedge clk);
    n_cmp++; if (dev_req !== 1'b0 || busy !== 1'b1 || owner !== 2'd2) begin n_err++; $display("FAIL hold_drop: got req %b busy %b owner %0d want 0/1/2", dev_req, busy, owner); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_drop_idle: got busy %b want 0", busy); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    set_host(2, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
    host_req = 3'b100;
    dev_gnt  = 1'b1;
    @(negedge clk);
    n_cmp++; if (host_gnt !== 3'b100) begin n_err++; $display("FAIL timeout_gnt: got %b want 100", host_gnt); end
    next_cycle();
    host_req  = 3'b000;
    dev_gnt   = 1'b0;
    dev_rdata = 32'hAAAA_5555;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++; if (host_rvalid !== 3'b000 || busy !== 1'b1) begin n_err++; $display("FAIL timeout_wait[%0d]: got rvalid %b busy %b want 000/1", c, host_rvalid, busy); end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++; if (host_rvalid !== 3'b100 || host_err !== 1'b1 || host_rdata !== 32'h0) begin n_err++; $display("FAIL timeout_err: got rvalid %b err %b rdata %h want 100/1/0", host_rvalid, host_err, host_rdata); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || host_rvalid !== 3'b000) begin n_err++; $display("FAIL timeout_idle: got busy %b rvalid %b want 0/000", busy, host_rvalid); end
    clear_inputs();
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    set_host(1, 1'b0, 4'hF, 32'h0000_0080, 32'h0);
    set_host(2, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
    host_req = 3'b010;
    dev_gnt  = 1'b1;
    next_cycle();
    dev_gnt    = 1'b0;
    host_req   = 3'b000;
    dev_rvalid = 1'b1;
    dev_rdata  = 32'h1111_2222;
    rst        = 1'b1;
    #1;
    n_cmp++; if (host_rvalid !== 3'b000 || host_rdata !== 32'h0 || busy !== 1'b0 || owner !== 2'd0) begin n_err++; $display("FAIL rst_resp_outputs: got rvalid %b rdata %h busy %b owner %0d want all 0", host_rvalid, host_rdata, busy, owner); end
    next_cycle();
    rst        = 1'b0;
    dev_rvalid = 1'b0;
    host_req   = 3'b110;
    dev_gnt    = 1'b1;
    @(negedge clk);
    n_cmp++; if (host_gnt !== 3'b010 || dev_addr !== 32'h80) begin n_err++; $display("FAIL rst_resp_first_gnt: got %b addr %h want 010/00000080", host_gnt, dev_addr); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_priority();
    test_hold_lock();
    test_timeout();
    test_reset_in_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
